// File: rtl/reg_display_bank.sv
// rtl/reg_display_bank.sv - 8x4 display register bank with sequential clear; SNAPSHOT_EN adds a freezable shadow
module reg_display_bank #(
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VAL = 4'h0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              clear_req,
    output logic              busy,
    output logic              clear_done,
    input  logic              freeze,
    output logic [DATA_W-1:0] reg0,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic [DATA_W-1:0] reg3,
    output logic [DATA_W-1:0] reg4,
    output logic [DATA_W-1:0] reg5,
    output logic [DATA_W-1:0] reg6,
    output logic [DATA_W-1:0] reg7
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, next_state;
    logic [2:0]        idx, next_idx;
    logic              done_next;
    logic              store_en;
    logic [2:0]        store_addr;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] r    [8];
    logic [DATA_W-1:0] disp [8];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= 3'd0;
            clear_done <= 1'b0;
        end else begin
            state      <= next_state;
            idx        <= next_idx;
            clear_done <= done_next;
        end
    end

    // A write and a clear request in the same IDLE cycle both take effect; CLEAR later overwrites the write.
    always_comb begin
        next_state = state;
        next_idx   = idx;
        done_next  = 1'b0;
        store_en   = 1'b0;
        store_addr = wr_addr;
        store_data = wr_data;
        case (state)
            IDLE: begin
                store_en = wr_en;
                if (clear_req) begin
                    next_state = CLEAR;
                    next_idx   = 3'd0;
                end
            end
            CLEAR: begin
                store_en   = 1'b1;
                store_addr = idx;
                store_data = CLEAR_VAL;
                next_idx   = idx + 3'd1;
                if (idx == 3'd7) begin
                    next_state = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else if (store_en) begin
            r[store_addr] <= store_data;
        end
    end

    assign busy      = (state == CLEAR);
    assign rd_data_a = r[rd_addr_a];
    assign rd_data_b = r[rd_addr_b];

`ifdef SNAPSHOT_EN
    logic [DATA_W-1:0] shadow [8];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) shadow[i] <= '0;
        end else if (!freeze) begin
            for (int i = 0; i < 8; i++) shadow[i] <= r[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) disp[i] = shadow[i];
    end
`else
    logic unused_freeze;
    assign unused_freeze = freeze;

    always_comb begin
        for (int i = 0; i < 8; i++) disp[i] = r[i];
    end
`endif

    // reg0 feeds the leftmost digit (HEX7), reg7 the rightmost (HEX0).
    assign reg0 = disp[0];
    assign reg1 = disp[1];
    assign reg2 = disp[2];
    assign reg3 = disp[3];
    assign reg4 = disp[4];
    assign reg5 = disp[5];
    assign reg6 = disp[6];
    assign reg7 = disp[7];

endmodule

// File: tb/tb_reg_display_bank.sv
// tb/tb_reg_display_bank.sv - directed self-checking bench for reg_display_bank
module tb_reg_display_bank;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [3:0] wr_data = 4'h0;
    logic [2:0] rd_addr_a = 3'd0;
    logic [2:0] rd_addr_b = 3'd0;
    logic [3:0] rd_data_a, rd_data_b;
    logic       clear_req = 1'b0;
    logic       busy, clear_done;
    logic       freeze = 1'b0;
    logic [3:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [31:0] regs;

    int checks = 0;
    int failures = 0;

    assign regs = {reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0};

    always #5 clock = ~clock;

    reg_display_bank dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .freeze(freeze),
        .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7)
    );

    task automatic test_reset();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'h7; clear_req = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", clear_done); end
        checks++; if (regs !== 32'h0) begin failures++; $display("FAIL reset_regs got=%h exp=00000000", regs); end
        reset = 1'b0; wr_en = 1'b0; clear_req = 1'b0; rd_addr_a = 3'd1;
        #1;
        checks++; if (rd_data_a !== 4'h0) begin failures++; $display("FAIL reset_rd1 got=%h exp=0", rd_data_a); end
    endtask

    task automatic test_write_read();
        @(negedge clock); wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
        @(negedge clock); wr_en = 1'b0; rd_addr_a = 3'd3;
        #1;
        checks++; if (rd_data_a !== 4'hA) begin failures++; $display("FAIL wr_rd_a got=%h exp=a", rd_data_a); end
        @(negedge clock);
        checks++; if (regs !== 32'h0000_A000) begin failures++; $display("FAIL wr_rd_regs got=%h exp=0000a000", regs); end
    endtask

    task automatic test_same_cycle();
        @(negedge clock); wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h5; rd_addr_b = 3'd2;
        #1;
        checks++; if (rd_data_b !== 4'h0) begin failures++; $display("FAIL same_old got=%h exp=0", rd_data_b); end
        @(negedge clock); wr_en = 1'b0;
        #1;
        checks++; if (rd_data_b !== 4'h5) begin failures++; $display("FAIL same_new got=%h exp=5", rd_data_b); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'h1;
        @(negedge clock); wr_addr = 3'd6; wr_data = 4'h2;
        @(negedge clock); wr_addr = 3'd5; wr_data = 4'h4;
        @(negedge clock); wr_en = 1'b0;
        @(negedge clock);
        checks++; if (regs !== 32'h0240_A500) begin failures++; $display("FAIL b2b_regs got=%h exp=0240a500", regs); end
    endtask

    task automatic test_clear();
        for (int j = 0; j < 8; j++) begin
            @(negedge clock); wr_en = 1'b1; wr_addr = j[2:0]; wr_data = 4'hF;
        end
        @(negedge clock); wr_en = 1'b0;
        @(negedge clock);
        checks++; if (regs !== 32'hFFFF_FFFF) begin failures++; $display("FAIL clr_fill got=%h exp=ffffffff", regs); end
        clear_req = 1'b1;
        @(negedge clock); clear_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            checks++; if (busy !== (i <= 8)) begin failures++; $display("FAIL clr_busy cyc=%0d got=%0b exp=%0b", i, busy, (i <= 8)); end
            checks++; if (clear_done !== (i == 9)) begin failures++; $display("FAIL clr_done cyc=%0d got=%0b exp=%0b", i, clear_done, (i == 9)); end
            @(negedge clock);
        end
        checks++; if (regs !== 32'h0) begin failures++; $display("FAIL clr_regs got=%h exp=00000000", regs); end
    endtask

    task automatic test_dropped_write();
        @(negedge clock); clear_req = 1'b1;
        @(negedge clock); clear_req = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            checks++; if (busy !== (i <= 8)) begin failures++; $display("FAIL drop_busy cyc=%0d got=%0b exp=%0b", i, busy, (i <= 8)); end
            checks++; if (clear_done !== (i == 9)) begin failures++; $display("FAIL drop_done cyc=%0d got=%0b exp=%0b", i, clear_done, (i == 9)); end
            if (i == 3) begin wr_en = 1'b1; wr_addr = 3'd7; wr_data = 4'h9; clear_req = 1'b1; end
            if (i == 4) begin wr_en = 1'b0; clear_req = 1'b0; end
            if (i == 8) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h9; end
            if (i == 9) wr_en = 1'b0;
            @(negedge clock);
        end
        rd_addr_a = 3'd7; rd_addr_b = 3'd0;
        #1;
        checks++; if (rd_data_a !== 4'h0) begin failures++; $display("FAIL drop_r7 got=%h exp=0", rd_data_a); end
        checks++; if (rd_data_b !== 4'h0) begin failures++; $display("FAIL drop_r0 got=%h exp=0", rd_data_b); end

        @(negedge clock); wr_en = 1'b1; wr_addr = 3'd4; wr_data = 4'hC; clear_req = 1'b1; rd_addr_a = 3'd4;
        @(negedge clock); wr_en = 1'b0; clear_req = 1'b0;
        #1;
        checks++; if (rd_data_a !== 4'hC) begin failures++; $display("FAIL both_wr got=%h exp=c", rd_data_a); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL both_busy got=%0b exp=1", busy); end
        repeat (10) @(negedge clock);
        #1;
        checks++; if (rd_data_a !== 4'h0) begin failures++; $display("FAIL both_cleared got=%h exp=0", rd_data_a); end
    endtask

    task automatic test_reset_abort();
        logic done_seen;
        for (int j = 0; j < 8; j++) begin
            @(negedge clock); wr_en = 1'b1; wr_addr = j[2:0]; wr_data = 4'hF;
        end
        @(negedge clock); wr_en = 1'b0; clear_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd2;
        @(negedge clock); clear_req = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (rd_data_a !== 4'hF) begin failures++; $display("FAIL abort_r3 got=%h exp=f", rd_data_a); end
        checks++; if (rd_data_b !== 4'h0) begin failures++; $display("FAIL abort_r2 got=%h exp=0", rd_data_b); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy4 got=%0b exp=1", busy); end
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", busy); end
        done_seen = clear_done;
        repeat (12) begin
            @(negedge clock);
            if (clear_done) done_seen = 1'b1;
        end
        checks++; if (done_seen !== 1'b0) begin failures++; $display("FAIL abort_done got=%0b exp=0", done_seen); end
        checks++; if (regs !== 32'h0) begin failures++; $display("FAIL abort_regs got=%h exp=00000000", regs); end
    endtask

    task automatic test_freeze();
        @(negedge clock); freeze = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h3;
        @(negedge clock); wr_en = 1'b0;
`ifdef SNAPSHOT_EN
        checks++; if (reg0 !== 4'h0) begin failures++; $display("FAIL frz_hold got=%h exp=0", reg0); end
        @(negedge clock);
        checks++; if (reg0 !== 4'h0) begin failures++; $display("FAIL frz_hold2 got=%h exp=0", reg0); end
        freeze = 1'b0;
        @(negedge clock);
        checks++; if (reg0 !== 4'h3) begin failures++; $display("FAIL frz_release got=%h exp=3", reg0); end
`else
        checks++; if (reg0 !== 4'h3) begin failures++; $display("FAIL frz_ignored got=%h exp=3", reg0); end
        freeze = 1'b0;
        @(negedge clock);
        checks++; if (reg0 !== 4'h3) begin failures++; $display("FAIL frz_after got=%h exp=3", reg0); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_back_to_back();
        test_clear();
        test_dropped_write();
        test_reset_abort();
        test_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_display_bank.md
REG_DISPLAY_BANK -- requirements
Module: reg_display_bank

Interface
REQ-001 Parameter: DATA_W, 4, register width in bits (fixed at 4 for this revision).
REQ-002 Parameter: CLEAR_VAL, 4'h0, value written to each register by the clear sequence.
REQ-003 Port: clock  in  1  single clock domain, rising-edge active.
REQ-004 Port: reset  in  1  synchronous, active-high.
REQ-005 Port: wr_en  in  1  write strobe.
REQ-006 Port: wr_addr  in  3  write register index.
REQ-007 Port: wr_data  in  4  write data.
REQ-008 Port: rd_addr_a / rd_addr_b  in  3 each  read indices.
REQ-009 Port: rd_data_a / rd_data_b  out  4 each  read data.
REQ-010 Port: clear_req  in  1  start the clear sequence.
REQ-011 Port: busy  out  1  clear sequence in progress.
REQ-012 Port: clear_done  out  1  one-cycle pulse on clear completion.
REQ-013 Port: freeze  in  1  hold the display outputs (effective only with SNAPSHOT_EN).
REQ-014 Port: reg0..reg7  out  4 each  display values for the downstream 7-segment writer.

Function
REQ-015 Storage SHALL be 8 registers, r[0]..r[7], each 4 bits.
REQ-016 With wr_en=1 in IDLE, r[wr_addr] SHALL take wr_data at the clock edge.
REQ-017 rd_data_a/rd_data_b SHALL be combinational reads of r[rd_addr_a]/r[rd_addr_b].
REQ-018 A read of the address being written in the same cycle SHALL return the old value; the new value appears the next cycle.
REQ-019 The FSM SHALL have two states, IDLE and CLEAR, with a 3-bit index idx.
REQ-020 IDLE with clear_req=1 SHALL go to CLEAR with idx=0.
REQ-021 In CLEAR, each cycle SHALL write r[idx]=CLEAR_VAL and increment idx.
REQ-022 After r[7] is written, the FSM SHALL return to IDLE.
REQ-023 The CLEAR sequence SHALL last exactly 8 cycles.
REQ-024 busy SHALL be 1 exactly while in CLEAR, i.e. for 8 cycles.
REQ-025 clear_done SHALL pulse high for one cycle, registered, on the first IDLE cycle after CLEAR.
REQ-026 wr_en while busy=1 SHALL be dropped, with no queueing.
REQ-027 clear_req while busy=1 SHALL be ignored, with no restart.
REQ-028 When wr_en and clear_req are both high in IDLE, the write SHALL be performed at that edge and CLEAR SHALL start at the same edge; the written value is then overwritten during CLEAR.
REQ-029 idx SHALL wrap from 7 back to 0, and no out-of-range access is possible.
REQ-030 Mapping: reg<i> SHALL show r[i] (or the snapshot of r[i]), so that reg0 drives the downstream HEX7 and reg7 drives HEX0.

Reset
REQ-031 reset=1 SHALL take priority over every other input at the clock edge.
REQ-032 On reset, r[0..7] SHALL be 0, state SHALL be IDLE, and idx SHALL be 0.
REQ-033 On reset, busy, clear_done and all reg0..reg7 outputs (including any snapshot) SHALL be 0.
REQ-034 Reset during CLEAR SHALL abort the sequence, and clear_done SHALL NOT pulse.

Configuration
REQ-035 Macro: SNAPSHOT_EN.
REQ-036 With SNAPSHOT_EN defined, reg0..reg7 SHALL come from a registered shadow copy of r[0..7].
REQ-037 With SNAPSHOT_EN defined and freeze=0, the shadow SHALL load every cycle, giving a 1-cycle display latency.
REQ-038 With SNAPSHOT_EN defined and freeze=1, the shadow SHALL hold its value while writes and clears continue to update r.
REQ-039 Without SNAPSHOT_EN, reg<i> SHALL equal r[i] combinationally, and freeze SHALL be present but ignored.

Verification
REQ-040 Write/read: after reset, write 4'hA to addr 3, then read rd_addr_a=3 on the next cycle -> 4'hA; all other registers read 0.
REQ-041 Same-cycle read: write 4'h5 to addr 2 while rd_addr_b=2 -> 4'h0 that cycle, then 4'h5 the following cycle.
REQ-042 Clear: fill all registers with 4'hF, pulse clear_req -> busy high for 8 cycles, clear_done pulses on the 9th cycle, and all registers read 0.
REQ-043 Dropped write: issue wr_en to addr 7 with 4'h9 during busy -> r[7]=0 after the clear; clear_req=wr_en=1 together in IDLE -> r[wr_addr]=0 after the clear.
REQ-044 Reset abort: assert reset on the 4th CLEAR cycle -> busy=0 the next cycle, clear_done never pulses, and all registers read 0.
REQ-045 SNAPSHOT_EN: hold freeze=1 and write 4'h3 to addr 0 -> reg0 stays at its old value; drop freeze -> reg0=4'h3 one cycle later.
